// File: rtl/mfp_ahb_acc_fifo_pkg.sv
// Shared register map and control-word layout for the accelerometer sample FIFO.
// Imported by mfp_ahb_acc_fifo; also the home of the decoder-visible offsets.
package mfp_ahb_acc_fifo_pkg;

    // Word offsets within the slave window (HADDR[5:2])
    localparam logic [3:0] AddrCtrl   = 4'd0;
    localparam logic [3:0] AddrStatus = 4'd1;
    localparam logic [3:0] AddrDataXy = 4'd2;
    localparam logic [3:0] AddrDataZ  = 4'd3;

    localparam int unsigned CtrlEnableBit  = 0;
    localparam int unsigned CtrlClearBit   = 1;
    localparam int unsigned CtrlThreshLsb  = 8;
    localparam int unsigned CtrlDivLsb     = 16;

    localparam int unsigned StatusEmptyBit = 8;
    localparam int unsigned StatusFullBit  = 9;
    localparam int unsigned StatusOvfBit   = 10;

    typedef struct packed {
        logic [15:0] div;
        logic [4:0]  thresh;
        logic        enable;
    } acc_ctrl_t;

    // CLEAR is a strobe and is never stored, so it always reads back as 0
    function automatic logic [31:0] ctrl_word(input acc_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CtrlEnableBit]       = c.enable;
        w[CtrlThreshLsb +: 5]  = c.thresh;
        w[CtrlDivLsb +: 16]    = c.div;
        return w;
    endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// Single-clock FIFO with synchronous clear; push and pop may occur in the same cycle,
// including when full (the freed slot takes the new entry) or empty (pop is ignored).
module mfp_sync_fifo #(
    parameter int unsigned WIDTH      = 36,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mfp_ahb_acc_fifo.sv
// AHB-lite slave that samples x/y/z acceleration at a programmable rate into a FIFO.
// Define MFP_ACC_FIFO_TS_EN to store a 16-bit cycle timestamp with each entry.
module mfp_ahb_acc_fifo
    import mfp_ahb_acc_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AW         = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [3:0]    HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [31:0]   HWDATA,
    input  logic          HWRITE,
    input  logic          HSEL,
    output logic [31:0]   HRDATA,
    input  logic [AW-1:0] x_acc,
    input  logic [AW-1:0] y_acc,
    input  logic [AW-1:0] z_acc,
    output logic          acc_irq
);

`ifdef MFP_ACC_FIFO_TS_EN
    localparam int unsigned EntryW = 3 * AW + 16;
`else
    localparam int unsigned EntryW = 3 * AW;
`endif

    acc_ctrl_t           ctrl_q;
    logic                wr_pend_q;
    logic [3:0]          wr_addr_q;
    logic [15:0]         div_q;
    logic                ovf_q;

    logic                aphase, rd_req, wr_ctrl, wr_status, clear;
    logic                tick, push, pop;
    logic [EntryW-1:0]   fifo_wdata, fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [31:0]         rd_val;
    logic                unused_bits;

    assign aphase    = HSEL & HTRANS[1];
    assign rd_req    = aphase & ~HWRITE;
    assign wr_ctrl   = wr_pend_q & (wr_addr_q == AddrCtrl);
    assign wr_status = wr_pend_q & (wr_addr_q == AddrStatus);
    assign clear     = wr_ctrl & HWDATA[CtrlClearBit];
    assign unused_bits = ^{HTRANS[0], HWDATA[7:2], HWDATA[15:13]};

    // Address phase is latched here; HWDATA arrives one edge later
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_pend_q <= aphase & HWRITE;
            wr_addr_q <= HADDR;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q.enable <= HWDATA[CtrlEnableBit];
            ctrl_q.thresh <= HWDATA[CtrlThreshLsb +: 5];
            ctrl_q.div    <= HWDATA[CtrlDivLsb +: 16];
        end
    end

    // >= rather than == so lowering DIV below the running count still ticks promptly
    assign tick = ctrl_q.enable & (div_q >= ctrl_q.div);
    assign push = tick & ~clear;
    assign pop  = rd_req & (HADDR == AddrDataZ) & ~fifo_empty;

    always_ff @(posedge HCLK) begin
        if (HRESET || clear || !ctrl_q.enable || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET || clear) begin
            ovf_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (wr_status && HWDATA[StatusOvfBit]) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef MFP_ACC_FIFO_TS_EN
    logic [15:0] ts_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) ts_q <= '0;
        else        ts_q <= ts_q + 16'd1;
    end

    assign fifo_wdata = {ts_q, z_acc, y_acc, x_acc};
`else
    assign fifo_wdata = {z_acc, y_acc, x_acc};
`endif

    mfp_sync_fifo #(
        .WIDTH      (EntryW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_val = '0;
        case (HADDR)
            AddrCtrl: rd_val = ctrl_word(ctrl_q);
            AddrStatus: begin
                rd_val[DEPTH_LOG2:0]   = fifo_count;
                rd_val[StatusEmptyBit] = fifo_empty;
                rd_val[StatusFullBit]  = fifo_full;
                rd_val[StatusOvfBit]   = ovf_q;
            end
            AddrDataXy: begin
                if (!fifo_empty) begin
                    rd_val[AW-1:0]  = fifo_rdata[AW-1:0];
                    rd_val[16 +: AW] = fifo_rdata[AW +: AW];
                end
            end
            AddrDataZ: begin
                if (!fifo_empty) begin
                    rd_val[AW-1:0] = fifo_rdata[2*AW +: AW];
`ifdef MFP_ACC_FIFO_TS_EN
                    rd_val[31:16]  = fifo_rdata[3*AW +: 16];
`endif
                end
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)      HRDATA <= '0;
        else if (rd_req) HRDATA <= rd_val;
    end

    assign acc_irq = ctrl_q.enable & (32'(fifo_count) >= 32'(ctrl_q.thresh));

endmodule

// File: tb/tb_mfp_ahb_acc_fifo.sv
// Directed bench for mfp_ahb_acc_fifo: register access, sampling rate, full/overflow,
// simultaneous push/pop, threshold IRQ, CLEAR and the optional timestamp field.
module tb_mfp_ahb_acc_fifo;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic [11:0] x_acc, y_acc, z_acc;
    logic        acc_irq;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    mfp_ahb_acc_fifo dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWDATA  (HWDATA),
        .HWRITE  (HWRITE),
        .HSEL    (HSEL),
        .HRDATA  (HRDATA),
        .x_acc   (x_acc),
        .y_acc   (y_acc),
        .z_acc   (z_acc),
        .acc_irq (acc_irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    // Leaves the bus idle after the address edge, so consecutive calls are back-to-back
    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, r1, r2;
        logic [15:0] ts_delta;

        HRESET = 1'b1; HADDR = '0; HTRANS = '0; HWDATA = '0; HWRITE = 1'b0; HSEL = 1'b0;
        x_acc = '0; y_acc = '0; z_acc = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state
        check("reset_hrdata", HRDATA, 32'h0);
        check("reset_irq", {31'h0, acc_irq}, 32'h0);
        read_check("reset_status", 4'd1, 32'h0000_0100);
        read_check("reset_data_z_empty", 4'd3, 32'h0);

        // DIV = 3: one sample every 4 cycles, 16 cycles -> 4 entries
        x_acc = 12'h123; y_acc = 12'h456; z_acc = 12'h789;
        bus_write(4'd0, 32'h0003_0001);
        repeat (16) @(posedge HCLK);
        #1;
        check("irq_thresh0_enabled", {31'h0, acc_irq}, 32'h1);
        read_check("div3_status", 4'd1, 32'h0000_0004);
        bus_write(4'd0, 32'h0003_0000);
        read_check("data_xy", 4'd2, 32'h0456_0123);
        read_check("data_z_pop", 4'd3, 32'h0000_0789);
        read_check("status_after_pop", 4'd1, 32'h0000_0003);

        // CLEAR + DIV = 0: fill with distinct samples, then overflow
        bus_write(4'd0, 32'h0000_0003);
        for (int i = 0; i < 16; i++) begin
            x_acc = 12'(i); y_acc = 12'(32'h100 + i); z_acc = 12'(32'h200 + i);
            @(posedge HCLK); #1;
        end
        x_acc = 12'hfff; y_acc = 12'hfff; z_acc = 12'hfff;
        repeat (5) @(posedge HCLK);
        #1;
        read_check("full_ovf_status", 4'd1, 32'h0000_0610);
        bus_write(4'd0, 32'h0000_0000);
        read_check("head_unchanged_by_ovf", 4'd2, 32'h0100_0000);
        bus_write(4'd1, 32'h0000_0400);
        read_check("ovf_w1c", 4'd1, 32'h0000_0210);

        // Full FIFO, DIV = 0, pop every cycle: push and pop coincide each edge
        x_acc = 12'h3aa; y_acc = 12'h3bb; z_acc = 12'h3cc;
        bus_write(4'd0, 32'h0000_0001);
        for (int i = 0; i < 16; i++) begin
            bus_read(4'd3, rd);
            check("pop_order_while_full", rd, 32'h200 + 32'(i));
        end
        read_check("full_push_pop_status", 4'd1, 32'h0000_0210);

        // Threshold IRQ and CLEAR discarding a coincident tick
        bus_write(4'd0, 32'h0000_0401);
        check("irq_full_thresh4", {31'h0, acc_irq}, 32'h1);
        bus_write(4'd0, 32'h0000_0403);
        read_check("clear_drops_tick", 4'd1, 32'h0000_0100);
        x_acc = 12'h111; y_acc = 12'h222; z_acc = 12'h333;
        bus_write(4'd0, 32'h0003_0403);
        check("irq_after_clear", {31'h0, acc_irq}, 32'h0);
        repeat (15) @(posedge HCLK);
        #1;
        check("irq_count3", {31'h0, acc_irq}, 32'h0);
        @(posedge HCLK); #1;
        check("irq_rise_count4", {31'h0, acc_irq}, 32'h1);
        read_check("irq_pop_data", 4'd3, 32'h0000_0333);
        check("irq_fall_count3", {31'h0, acc_irq}, 32'h0);
        repeat (3) @(posedge HCLK);
        #1;
        check("irq_rise_again", {31'h0, acc_irq}, 32'h1);
        bus_write(4'd0, 32'h0003_0403);
        check("irq_clear_midfill", {31'h0, acc_irq}, 32'h0);
        read_check("status_clear_midfill", 4'd1, 32'h0000_0100);

        // DIV = 9: two samples ten cycles apart
        bus_write(4'd0, 32'h0009_0003);
        repeat (25) @(posedge HCLK);
        #1;
        bus_write(4'd0, 32'h0009_0000);
        read_check("ctrl_readback", 4'd0, 32'h0009_0000);
        bus_read(4'd3, r1);
        bus_read(4'd3, r2);
        check("ts_entry1_z", {20'h0, r1[11:0]}, 32'h0000_0333);
        check("ts_entry2_z", {20'h0, r2[11:0]}, 32'h0000_0333);
`ifdef MFP_ACC_FIFO_TS_EN
        ts_delta = r2[31:16] - r1[31:16];
        check("ts_delta", {16'h0, ts_delta}, 32'd10);
`else
        ts_delta = 16'h0;
        check("ts_absent_1", {16'h0, r1[31:16]}, {16'h0, ts_delta});
        check("ts_absent_2", {16'h0, r2[31:16]}, 32'h0);
`endif
        read_check("drained_status", 4'd1, 32'h0000_0100);
        read_check("data_z_empty_again", 4'd3, 32'h0);
        bus_write(4'd7, 32'hffff_ffff);
        read_check("unmapped_read", 4'd7, 32'h0);
        read_check("ctrl_after_unmapped_write", 4'd0, 32'h0009_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
